qar_timer_wdt: RTL and testbench
================================

Name: qar_timer_wdt

Overview:
- Memory-mapped timer and watchdog peripheral on the qar_core data bus; drives the core's irq_timer input and consumes irq_timer_ack.
- Provides a prescaled up-counter with compare/auto-reload, and a down-counting watchdog with a magic-value kick.
- STATUS encoding is bit0 = timer fired, bit2 = watchdog expired. Firmware timer demos copy these bits to DMEM.

Parameters:
- CNT_WIDTH, 32, width of COUNT, COMPARE, WDT_LOAD and the watchdog counter.
- PRESC_WIDTH, 16, width of the PRESCALE register.
- KICK_MAGIC, 32'h5A5A_A5A5, the only WDT_KICK write value that reloads the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- bus_valid  in  1  access request; already address-decoded for this block.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  32  byte address; only [4:2] decoded.
- bus_wdata  in  32  write data.
- bus_ready  out  1  access complete.
- bus_rdata  out  32  read data, valid while bus_ready = 1.
- irq_timer  out  1  level interrupt to core.
- irq_timer_ack  in  1  one-cycle acknowledge from core.
- wdt_reset_req  out  1  one-cycle system reset request.

Behaviour:
- Reset (rst = 1 at a clk edge): all registers, counters and outputs go to 0, including bus_ready, bus_rdata, irq_timer and wdt_reset_req.
- Register map, word offsets:
  - 0x00 CTRL: bit0 TEN, bit1 PERIODIC, bit2 IEN, bit4 WEN, bit5 WRST_EN.
  - 0x04 STATUS: bit0 TFIRED, bit2 WEXP; write-1-to-clear.
  - 0x08 COMPARE.
  - 0x0C COUNT: read/write.
  - 0x10 WDT_LOAD.
  - 0x14 WDT_KICK: write-only, reads 0.
  - 0x18 PRESCALE.
  - 0x1C: reserved; reads 0, writes ignored.
- Bus handshake:
  - bus_ready is registered: bus_ready <= bus_valid & ~bus_ready. Single-cycle pulse, one cycle after valid, so latency is 1 cycle.
  - The master holds valid, we, addr and wdata until ready.
  - Write side-effects commit on the edge where bus_ready is 1. Read data is sampled into bus_rdata on the same edge that raises ready.
  - Back-to-back accesses therefore take 2 cycles each.
- Prescaler:
  - presc_cnt counts 0..PRESCALE, then wraps to 0.
  - tick = 1 in the cycle presc_cnt == PRESCALE. PRESCALE = 0 gives a tick every cycle.
  - presc_cnt runs whenever TEN or WEN is set, and is held at 0 otherwise.
- Timer, on each tick with TEN = 1:
  - If COUNT == COMPARE: set TFIRED. If PERIODIC = 1, COUNT <= 0; otherwise COUNT holds and TEN clears (one-shot).
  - Else COUNT <= COUNT + 1, wrapping modulo 2^CNT_WIDTH.
  - COMPARE = 0 fires on every tick.
- irq_timer = TFIRED & IEN, combinational from registers.
- irq_timer_ack clears TFIRED on the next edge.
- Watchdog counter (wcnt):
  - Loaded from WDT_LOAD on a write that sets WEN from 0 to 1.
  - Also loaded on a WDT_KICK write equal to KICK_MAGIC while WEN = 1. Any other kick value is ignored.
  - Decrements on each tick while WEN = 1 and wcnt != 0.
  - When wcnt == 0 with WEN = 1: set WEXP. If WRST_EN = 1, pulse wdt_reset_req for exactly one cycle, on WEXP's 0 to 1 transition only. wcnt stays at 0 until reload.
  - WDT_LOAD = 0 with WEN set expires on the first cycle after enable.
- Simultaneous events:
  - Hardware set of TFIRED or WEXP beats a same-cycle W1C or ack (status stays 1).
  - A software write to COUNT beats a same-cycle tick update.
  - A kick beats a same-cycle decrement.
  - A CTRL write clearing TEN beats a same-cycle one-shot fire; TFIRED is still set.
- Reset mid-access: bus_ready drops to 0 and the pending access is discarded. The master must reissue it.

Decomposition:
- Package qar_timer_pkg: register offset constants (REG_CTRL..REG_PRESCALE), CTRL/STATUS bit indices, default KICK_MAGIC.
- One sub-module, qar_prescaler: counter plus tick output, shared by timer and watchdog.
- Register file, timer and watchdog stay in the top module.

Test Plan:
- Reset then read all registers -> every read returns 0; irq_timer = 0; wdt_reset_req = 0; each read's bus_ready is high exactly 1 cycle after valid.
- PRESCALE = 3, COMPARE = 4, CTRL = 0x5 (one-shot, IEN) -> irq_timer rises 20 cycles after the CTRL write commits; COUNT holds 4; CTRL reads 0x4; STATUS = 0x1.
- Periodic mode: PRESCALE = 0, COMPARE = 2, CTRL = 0x7 -> TFIRED sets every 3 cycles. Pulse irq_timer_ack -> irq_timer drops next cycle and re-asserts 3 cycles after the previous fire.
- Watchdog: WDT_LOAD = 10, PRESCALE = 0, CTRL = 0x30 -> STATUS bit2 set, and wdt_reset_req high for exactly 1 cycle, 11 cycles after enable. Kicks with 0x5A5AA5A5 every 8 cycles -> WEXP never sets. A kick with 0x12345678 -> ignored.
- Collision: W1C STATUS = 0x1 committing on the same edge TFIRED sets -> STATUS reads 0x1. A COUNT write of 100 on a tick edge -> COUNT reads 100.
- Firmware-style run (timer one-shot fire, then watchdog expiry with WRST_EN = 0) -> STATUS bit0 read = 0x1 and STATUS & 0x4 = 0x4. These match the DMEM[0]/DMEM[1] expectations of the core-level timer demo.

Source files
------------

// File: rtl/qar_timer_pkg.sv
// qar_timer_pkg: register offsets, control/status bit indices and kick magic for qar_timer_wdt
package qar_timer_pkg;
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_WDT_LOAD = 3'd4;
  localparam logic [2:0] REG_WDT_KICK = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam int CTRL_TEN      = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IEN      = 2;
  localparam int CTRL_WEN      = 4;
  localparam int CTRL_WRST_EN  = 5;
  localparam int ST_TFIRED = 0;
  localparam int ST_WEXP   = 2;
  localparam logic [31:0] DEFAULT_KICK_MAGIC = 32'h5A5A_A5A5;
endpackage

// File: rtl/qar_prescaler.sv
// qar_prescaler: counts 0..presc and emits a tick on the terminal count while enabled
module qar_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] presc,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = en & (cnt == presc);
  // wrap at the terminal count (or above it, if presc shrank underneath us); hold at 0 when disabled
  always_ff @(posedge clk)
    cnt <= (rst | ~en | (cnt >= presc)) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/qar_timer_wdt.sv
// qar_timer_wdt: bus-mapped prescaled compare timer with a magic-kick down-counting watchdog
module qar_timer_wdt
  import qar_timer_pkg::*;
#(
  parameter int          CNT_WIDTH   = 32,
  parameter int          PRESC_WIDTH = 16,
  parameter logic [31:0] KICK_MAGIC  = DEFAULT_KICK_MAGIC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        irq_timer,
  input  logic        irq_timer_ack,
  output logic        wdt_reset_req
);
  logic ten, periodic, ien, wen, wrst_en, tfired, wexp;
  logic [CNT_WIDTH-1:0] compare, count, wdt_load, wcnt;
  logic [PRESC_WIDTH-1:0] prescale;
  logic tick, wr, rd, tfire, wset, wen_rise, kick_ok;
  logic w_ctrl, w_status, w_compare, w_count, w_load, w_kick, w_presc;
  logic [2:0] a;
  logic [31:0] rmux;
  logic unused_addr;
  assign unused_addr = ^{bus_addr[31:5], bus_addr[1:0]};
  assign a = bus_addr[4:2];
  assign wr = bus_valid & bus_we & bus_ready;
  assign rd = bus_valid & ~bus_we & ~bus_ready;
  assign w_ctrl    = wr & (a == REG_CTRL);
  assign w_status  = wr & (a == REG_STATUS);
  assign w_compare = wr & (a == REG_COMPARE);
  assign w_count   = wr & (a == REG_COUNT);
  assign w_load    = wr & (a == REG_WDT_LOAD);
  assign w_kick    = wr & (a == REG_WDT_KICK);
  assign w_presc   = wr & (a == REG_PRESCALE);
  assign tfire    = tick & ten & (count == compare);
  assign wset     = wen & (wcnt == '0);
  assign wen_rise = w_ctrl & bus_wdata[CTRL_WEN] & ~wen;
  assign kick_ok  = w_kick & wen & (bus_wdata == KICK_MAGIC);
  assign irq_timer = tfired & ien;
  qar_prescaler #(.W(PRESC_WIDTH)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (ten | wen),
    .presc(prescale),
    .tick (tick)
  );
  // read-data selection from the current register state
  always_comb begin
    rmux = '0;
    case (a)
      REG_CTRL:     rmux = {26'd0, wrst_en, wen, 1'b0, ien, periodic, ten};
      REG_STATUS:   rmux = {29'd0, wexp, 1'b0, tfired};
      REG_COMPARE:  rmux = 32'(compare);
      REG_COUNT:    rmux = 32'(count);
      REG_WDT_LOAD: rmux = 32'(wdt_load);
      REG_PRESCALE: rmux = 32'(prescale);
      default:      rmux = '0;
    endcase
  end
  // one-cycle ready pulse; read data captured on the edge that raises ready
  always_ff @(posedge clk) begin
    bus_ready <= ~rst & bus_valid & ~bus_ready;
    bus_rdata <= (~rst & rd) ? rmux : '0;
  end
  // plain configuration registers
  always_ff @(posedge clk)
    if (rst) begin
      {periodic, ien, wen, wrst_en} <= '0;
      compare  <= '0;
      wdt_load <= '0;
      prescale <= '0;
    end else begin
      if (w_ctrl) {wrst_en, wen, ien, periodic} <= {bus_wdata[CTRL_WRST_EN], bus_wdata[CTRL_WEN], bus_wdata[CTRL_IEN], bus_wdata[CTRL_PERIODIC]};
      if (w_compare) compare <= bus_wdata[CNT_WIDTH-1:0];
      if (w_load) wdt_load <= bus_wdata[CNT_WIDTH-1:0];
      if (w_presc) prescale <= bus_wdata[PRESC_WIDTH-1:0];
    end
  // timer: a software CTRL/COUNT write wins over the same-cycle tick update
  always_ff @(posedge clk) begin
    ten    <= rst ? 1'b0 : w_ctrl ? bus_wdata[CTRL_TEN] : (tfire & ~periodic) ? 1'b0 : ten;
    count  <= rst ? '0 : w_count ? bus_wdata[CNT_WIDTH-1:0] : (tick & ten) ? (tfire ? (periodic ? '0 : count) : count + 1'b1) : count;
    tfired <= ~rst & (tfire | (tfired & ~(w_status & bus_wdata[ST_TFIRED]) & ~irq_timer_ack));
  end
  // watchdog: reload on enable or valid kick, otherwise count down on ticks and latch expiry
  always_ff @(posedge clk) begin
    wcnt          <= rst ? '0 : (wen_rise | kick_ok) ? wdt_load : (wen & tick & (wcnt != '0)) ? wcnt - 1'b1 : wcnt;
    wexp          <= ~rst & (wset | (wexp & ~(w_status & bus_wdata[ST_WEXP])));
    wdt_reset_req <= ~rst & wset & ~wexp & wrst_en;
  end
endmodule

// File: tb/tb_qar_timer_wdt.sv
// tb_qar_timer_wdt: directed table plus hand-written sequences for the timer/watchdog peripheral
module tb_qar_timer_wdt;
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  logic clk = 0, rst = 1, bus_valid = 0, bus_we = 0, irq_timer_ack = 0;
  logic [31:0] bus_addr = 0, bus_wdata = 0;
  logic bus_ready, irq_timer, wdt_reset_req;
  logic [31:0] bus_rdata;
  int vectors = 0, miscompares = 0, pulses = 0;
  qar_timer_wdt dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .irq_timer(irq_timer), .irq_timer_ack(irq_timer_ack), .wdt_reset_req(wdt_reset_req)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wdt_reset_req) pulses <= pulses + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1; bus_valid = 0; irq_timer_ack = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d, output logic [31:0] q);
    int n = 0;
    bus_valid = 1; bus_we = we; bus_addr = {27'd0, a}; bus_wdata = d;
    do begin @(posedge clk); #1; n++; end while (!bus_ready && n < 8);
    chk("ready_latency", n, 1);
    q = bus_rdata;
    @(posedge clk); #1;
    bus_valid = 0;
  endtask
  task automatic wait_hi(input bit sel_wdt, input int budget, output int n);
    n = 0;
    while (!(sel_wdt ? wdt_reset_req : irq_timer) && n < budget) begin @(posedge clk); #1; n++; end
  endtask
  initial begin
    vec_t tbl[26];
    logic [31:0] q;
    int n, p0;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 5'(i * 4), 32'h0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 5'h08, 32'h0000_1234, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 5'h08, 32'h0,         1'b1, 32'h0000_1234};
    tbl[10] = '{1'b1, 5'h0C, 32'h0000_0007, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 5'h0C, 32'h0,         1'b1, 32'h0000_0007};
    tbl[12] = '{1'b1, 5'h10, 32'h0000_0055, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 5'h10, 32'h0,         1'b1, 32'h0000_0055};
    tbl[14] = '{1'b1, 5'h18, 32'hABCD_1234, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 5'h18, 32'h0,         1'b1, 32'h0000_1234};
    tbl[16] = '{1'b1, 5'h14, 32'h5A5A_A5A5, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 5'h14, 32'h0,         1'b1, 32'h0};
    tbl[18] = '{1'b1, 5'h1C, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 5'h1C, 32'h0,         1'b1, 32'h0};
    tbl[20] = '{1'b1, 5'h00, 32'h0000_002C, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 5'h00, 32'h0,         1'b1, 32'h0000_0024};
    tbl[22] = '{1'b1, 5'h04, 32'h0000_0005, 1'b0, 32'h0};
    tbl[23] = '{1'b0, 5'h04, 32'h0,         1'b1, 32'h0};
    tbl[24] = '{1'b1, 5'h00, 32'h0,         1'b0, 32'h0};
    tbl[25] = '{1'b0, 5'h00, 32'h0,         1'b1, 32'h0};
    do_reset();
    chk("rst_ready", bus_ready, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_irq", irq_timer, 0);
    chk("rst_wdt", wdt_reset_req, 0);
    for (int i = 0; i < 26; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, q);
      if (tbl[i].chk) chk($sformatf("tbl[%0d]", i), q, tbl[i].exp);
    end
    chk("ready_idle", bus_ready, 0);
    // one-shot: 4 cycles per tick, fire on the 5th tick
    do_reset();
    bus(1, 5'h18, 3, q);
    bus(1, 5'h08, 4, q);
    bus(1, 5'h00, 32'h5, q);
    chk("oneshot_irq_low", irq_timer, 0);
    wait_hi(0, 40, n);
    chk("oneshot_delay", n, 20);
    bus(0, 5'h0C, 0, q); chk("oneshot_count", q, 4);
    bus(0, 5'h00, 0, q); chk("oneshot_ctrl", q, 32'h4);
    bus(0, 5'h04, 0, q); chk("oneshot_status", q, 32'h1);
    // periodic with ack
    do_reset();
    bus(1, 5'h18, 0, q);
    bus(1, 5'h08, 2, q);
    bus(1, 5'h00, 32'h7, q);
    wait_hi(0, 10, n);
    chk("periodic_first", n, 3);
    irq_timer_ack = 1;
    @(posedge clk); #1 irq_timer_ack = 0;
    chk("periodic_ack_drop", irq_timer, 0);
    wait_hi(0, 10, n);
    chk("periodic_refire", n + 1, 3);
    // watchdog expiry with reset request
    do_reset();
    bus(1, 5'h10, 10, q);
    p0 = pulses;
    bus(1, 5'h00, 32'h30, q);
    wait_hi(1, 20, n);
    chk("wdt_delay", n, 11);
    repeat (5) @(posedge clk);
    #1 chk("wdt_one_pulse", pulses - p0, 1);
    bus(0, 5'h04, 0, q); chk("wdt_status", q, 32'h4);
    // periodic kicks keep it alive; a wrong magic is ignored
    do_reset();
    bus(1, 5'h10, 10, q);
    p0 = pulses;
    bus(1, 5'h00, 32'h30, q);
    for (int k = 0; k < 6; k++) begin
      repeat (6) @(posedge clk);
      #1 bus(1, 5'h14, 32'h5A5A_A5A5, q);
    end
    bus(0, 5'h04, 0, q); chk("kick_status", q, 0);
    chk("kick_no_pulse", pulses - p0, 0);
    bus(1, 5'h14, 32'h1234_5678, q);
    wait_hi(1, 20, n);
    chk("badkick_delay", n, 7);
    // W1C colliding with a hardware set, then a W1C that does clear
    do_reset();
    bus(1, 5'h08, 2, q);
    bus(1, 5'h00, 32'h3, q);
    @(posedge clk); #1;
    bus(1, 5'h04, 32'h1, q);
    bus(0, 5'h04, 0, q); chk("w1c_collide", q, 32'h1);
    bus(1, 5'h04, 32'h1, q);
    bus(0, 5'h04, 0, q); chk("w1c_clear", q, 0);
    // COUNT write on a tick edge
    do_reset();
    bus(1, 5'h08, 1000, q);
    bus(1, 5'h00, 32'h1, q);
    bus(1, 5'h0C, 100, q);
    bus(0, 5'h0C, 0, q); chk("count_write_wins", q, 100);
    // firmware-style: one-shot fire then watchdog expiry without reset request
    do_reset();
    bus(1, 5'h18, 1, q);
    bus(1, 5'h08, 3, q);
    bus(1, 5'h00, 32'h1, q);
    q = 0;
    for (int i = 0; i < 20 && !q[0]; i++) bus(0, 5'h04, 0, q);
    chk("fw_tfired", q & 32'h1, 32'h1);
    bus(1, 5'h10, 5, q);
    p0 = pulses;
    bus(1, 5'h00, 32'h10, q);
    q = 0;
    for (int i = 0; i < 20 && !q[2]; i++) bus(0, 5'h04, 0, q);
    chk("fw_wexp", q & 32'h4, 32'h4);
    chk("fw_tfired_kept", q & 32'h1, 32'h1);
    chk("fw_no_reset_req", pulses - p0, 0);
    // reset in the middle of a write discards it
    bus_valid = 1; bus_we = 1; bus_addr = 32'h08; bus_wdata = 32'h77;
    @(posedge clk); #1 chk("midrst_ready_hi", bus_ready, 1);
    rst = 1;
    @(posedge clk); #1 chk("midrst_ready_lo", bus_ready, 0);
    rst = 0; bus_valid = 0;
    bus(0, 5'h08, 0, q); chk("midrst_discard", q, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
